udp_port_dispatch_ctrl: RTL

Control-side companion to udp_demux. It snoops the UDP header and payload handshakes on the demux input and matches s_udp_dest_port against a programmable table of M_COUNT port entries. It drives the demux enable/drop/select controls so each frame is steered to the matching output, or dropped when no entry matches. Select and drop are held stable from decision until the frame's tlast beat completes.

---
 rtl/udp_port_dispatch_ctrl_if.sv | 24 ++
 rtl/udp_port_dispatch_ctrl.sv | 80 ++++++++
 2 files changed

// File: rtl/udp_port_dispatch_ctrl_if.sv
// udp_port_dispatch_ctrl_if: snooped udp_demux input handshakes and demux enable/drop/select controls; master=demux side, slave=dispatch controller
interface udp_port_dispatch_ctrl_if #(
  parameter int SELECT_WIDTH = 2
);
  logic s_udp_hdr_valid;
  logic s_udp_hdr_ready;
  logic [15:0] s_udp_dest_port;
  logic s_udp_payload_axis_tvalid;
  logic s_udp_payload_axis_tready;
  logic s_udp_payload_axis_tlast;
  logic enable;
  logic drop;
  logic [SELECT_WIDTH-1:0] select;
  modport master (
    output s_udp_hdr_valid, s_udp_hdr_ready, s_udp_dest_port,
    output s_udp_payload_axis_tvalid, s_udp_payload_axis_tready, s_udp_payload_axis_tlast,
    input enable, drop, select
  );
  modport slave (
    input s_udp_hdr_valid, s_udp_hdr_ready, s_udp_dest_port,
    input s_udp_payload_axis_tvalid, s_udp_payload_axis_tready, s_udp_payload_axis_tlast,
    output enable, drop, select
  );
endinterface

// File: rtl/udp_port_dispatch_ctrl.sv
// udp_port_dispatch_ctrl: steers udp_demux by dest-port table lookup; ports: clk/rst, bus (snoop in, enable/drop/select out), ctrl_enable, cfg_* table write, busy, stat_* saturating counters
module udp_port_dispatch_ctrl #(
  parameter int M_COUNT = 4,
  parameter int SELECT_WIDTH = $clog2(M_COUNT),
  parameter int STAT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  udp_port_dispatch_ctrl_if.slave bus,
  input  logic ctrl_enable,
  input  logic cfg_wr_en,
  input  logic [SELECT_WIDTH-1:0] cfg_addr,
  input  logic [15:0] cfg_port,
  input  logic cfg_entry_valid,
  output logic busy,
  output logic [STAT_WIDTH-1:0] stat_frame_count,
  output logic [STAT_WIDTH-1:0] stat_drop_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DECIDE = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  logic [1:0] state;
  logic en_q, drop_q, hdr_done, pay_done, hit;
  logic [SELECT_WIDTH-1:0] sel_q, idx;
  logic [M_COUNT-1:0] tbl_valid;
  logic [M_COUNT-1:0][15:0] tbl_port;
  logic hdr_hs, pay_hs, hdr_fin, pay_fin;
  assign bus.enable = en_q;
  assign bus.drop = drop_q;
  assign bus.select = sel_q;
  assign busy = state != IDLE;
  assign hdr_hs = en_q && bus.s_udp_hdr_valid && bus.s_udp_hdr_ready;
  assign pay_hs = en_q && bus.s_udp_payload_axis_tvalid && bus.s_udp_payload_axis_tready && bus.s_udp_payload_axis_tlast;
  assign hdr_fin = hdr_done || hdr_hs;
  assign pay_fin = pay_done || pay_hs;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = M_COUNT - 1; i >= 0; i--)
      if (tbl_valid[i] && tbl_port[i] == bus.s_udp_dest_port) begin
        hit = 1'b1;
        idx = SELECT_WIDTH'(i);
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      en_q <= 1'b0;
      drop_q <= 1'b0;
      sel_q <= '0;
      hdr_done <= 1'b0;
      pay_done <= 1'b0;
      tbl_valid <= '0;
      tbl_port <= '0;
      stat_frame_count <= '0;
      stat_drop_count <= '0;
    end else begin
      if (cfg_wr_en && int'(cfg_addr) < M_COUNT) begin
        tbl_valid[cfg_addr] <= cfg_entry_valid;
        tbl_port[cfg_addr] <= cfg_port;
      end
      if (hdr_hs && drop_q && !(&stat_drop_count)) stat_drop_count <= stat_drop_count + 1'b1;
      if (hdr_hs && !drop_q && !(&stat_frame_count)) stat_frame_count <= stat_frame_count + 1'b1;
      if (state == IDLE && bus.s_udp_hdr_valid && ctrl_enable) begin
        sel_q <= idx;
        drop_q <= !hit;
        state <= DECIDE;
      end
      if (state == DECIDE) begin
        en_q <= 1'b1;
        state <= ACTIVE;
      end
      if (state == ACTIVE) begin
        hdr_done <= hdr_fin && !pay_fin;
        pay_done <= pay_fin && !hdr_fin;
        en_q <= !(hdr_fin && pay_fin);
        state <= hdr_fin && pay_fin ? IDLE : ACTIVE;
      end
    end
endmodule
